click_classifier: RTL

//   Consumes the 1-cycle debounced press pulses produced by the button debouncer.

---
 rtl/click_classifier.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/click_classifier.sv
// rtl/click_classifier.sv - groups debounced press pulses into single/double/triple click events
//
// Purpose:
//   Groups 1-cycle press pulses that fall within a click window into click
//   events. The events are queued in a small FIFO and presented on a
//   valid/ready interface.
//
// Configuration macro:
//   CLICK_TRIPLE_EN
//     Defined:   a third in-window press emits code 11 immediately.
//     Undefined: a third press closes the double (code 10) and starts a new
//                sequence.
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   press       in   1-cycle debounced press pulse
//   evt_valid   out  event queue non-empty
//   evt_ready   in   consumer accepts the head event
//   evt_code    out  01 single, 10 double, 11 triple, 00 when empty
//   drop_count  out  events lost to a full queue, saturating at 255
module click_classifier #(
  parameter int CLK_FREQUENCY   = 10_000_000,
  parameter int CLICK_WINDOW_HZ = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       press,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic [7:0] drop_count
);

  localparam int WINDOW = CLK_FREQUENCY / CLICK_WINDOW_HZ;
  localparam int TW     = $clog2(WINDOW);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ONE, S_TWO} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic            timeout;
  logic            push;
  logic [1:0]      push_code;

  logic [1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            do_pop;
  logic            do_push;

  assign timeout = (timer == TW'(WINDOW - 1));

  // Next-state and push decision; a press always takes priority over the
  // timeout in the same cycle, so it counts as in-window.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_code = 2'b00;
    case (state)
      S_IDLE: begin
        if (press) state_nxt = S_ONE;
      end
      S_ONE: begin
        if (press) begin
          state_nxt = S_TWO;
        end else if (timeout) begin
          push      = 1'b1;
          push_code = 2'b01;
          state_nxt = S_IDLE;
        end
      end
      S_TWO: begin
        if (press) begin
          push = 1'b1;
`ifdef CLICK_TRIPLE_EN
          push_code = 2'b11;
          state_nxt = S_IDLE;
`else
          // The third press closes the double and opens a fresh sequence.
          push_code = 2'b10;
          state_nxt = S_ONE;
`endif
        end else if (timeout) begin
          push      = 1'b1;
          push_code = 2'b10;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The timer restarts on every state entry, including TWO -> ONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE) timer <= '0;
      else                                       timer <= timer + TW'(1);
    end
  end

  // Event queue. When full, a push only lands if a pop frees the slot in the
  // same cycle; otherwise it is counted as a drop.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? mem[rd_ptr] : 2'b00;
  assign do_pop    = evt_valid && evt_ready;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !do_push && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule
